// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  localparam int STEPS_MUL_DEF = 16;
  localparam int STEPS_DIV_DEF = 32;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Start/result handshake and datapath control bundle.
interface multdiv_ctrl_if #(
  parameter int CW = 5
);

  logic          ctrl_MULT;
  logic          ctrl_DIV;
  logic          divisor_zero;
  logic          mul_overflow;
  logic          load;
  logic          step;
  logic          mode_div;
  logic [CW-1:0] count;
  logic          busy;
  logic          data_resultRDY;
  logic          data_exception;

  modport master (
    output ctrl_MULT,
    output ctrl_DIV,
    output divisor_zero,
    output mul_overflow,
    input  load,
    input  step,
    input  mode_div,
    input  count,
    input  busy,
    input  data_resultRDY,
    input  data_exception
  );

  modport slave (
    input  ctrl_MULT,
    input  ctrl_DIV,
    input  divisor_zero,
    input  mul_overflow,
    output load,
    output step,
    output mode_div,
    output count,
    output busy,
    output data_resultRDY,
    output data_exception
  );

endinterface

// File: rtl/multdiv_ctrl_tff_counter.sv
// Iteration counter: one toggle flop per bit, rippled carry,
// synchronous clear overriding enable.
module tff_counter #(
  parameter int CW = 5
) (
  input  logic          clock,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);

  logic [CW-1:0] q_q;
  logic [CW-1:0] q_d;

  always_comb begin
    logic carry;
    carry = en;
    q_d   = '0;
    for (int i = 0; i < CW; i++) begin
      q_d[i] = clr ? 1'b0 : (q_q[i] ^ carry);
      carry  = carry & q_q[i];
    end
  end

  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer: IDLE -> LOAD -> RUN -> DONE.
// MULTDIV_DIV0_FAST_EN: divide-by-zero skips RUN.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int STEPS_MUL = STEPS_MUL_DEF,
  parameter int STEPS_DIV = STEPS_DIV_DEF,
  parameter int CW        = $clog2(STEPS_DIV)
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_ctrl_if.slave  bus
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic          exc_q, exc_d;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          cnt_en;
  logic          start;
  logic          last;
  mode_e         start_mode;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign start_mode = bus.ctrl_MULT ? MODE_MUL
                                    : MODE_DIV;

  assign last = (mode_q == MODE_DIV)
              ? (cnt == CW'(STEPS_DIV - 1))
              : (cnt == CW'(STEPS_MUL - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    exc_d   = exc_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    // A start in any state (re)launches; aborted ops never report.
    if (start) begin
      state_d = LOAD;
      mode_d  = start_mode;
      exc_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        LOAD: begin
          state_d = RUN;
          if (mode_q == MODE_DIV) begin
            exc_d = bus.divisor_zero;
          end
`ifdef MULTDIV_DIV0_FAST_EN
          if (mode_q == MODE_DIV && bus.divisor_zero) begin
            state_d = DONE;
          end
`endif
        end
        RUN: begin
          cnt_en  = 1'b1;
          cnt_clr = last;
          if (last) begin
            state_d = DONE;
            if (mode_q == MODE_MUL) begin
              exc_d = exc_q | bus.mul_overflow;
            end
          end
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_MUL;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      exc_q   <= exc_d;
    end
  end

  tff_counter #(
    .CW (CW)
  ) u_cnt (
    .clock (clock),
    .clr   (cnt_clr | reset),
    .en    (cnt_en),
    .q     (cnt)
  );

  assign bus.load           = (state_q == LOAD);
  assign bus.step           = (state_q == RUN);
  assign bus.busy           = bus.load | bus.step;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.data_exception = (state_q == DONE) & exc_q;
  assign bus.mode_div       = (state_q != IDLE)
                            & (mode_q == MODE_DIV);
  assign bus.count          = cnt;

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the iterative multiply/divide unit in the processor's execute stage. Accepts single-cycle `ctrl_MULT`/`ctrl_DIV` start pulses, loads operands into the shared shift/add datapath, issues one `step` per iteration for the selected operation, then raises a one-cycle `data_resultRDY` with `data_exception`. Sole owner of the datapath's load/step/mode controls; the pipeline stalls on `busy`.

## Interface
- `STEPS_MUL`, default 16: iterations per multiply (radix-4 Booth on 32-bit operands).
- `STEPS_DIV`, default 32: iterations per divide (restoring, one quotient bit per step).
- `CW`, default `$clog2(STEPS_DIV)`: iteration-counter width; must hold `max(STEPS_MUL, STEPS_DIV) - 1`.

- `clock` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `ctrl_MULT` in 1: start-multiply pulse.
- `ctrl_DIV` in 1: start-divide pulse.
- `divisor_zero` in 1: datapath flag, valid in LOAD cycle.
- `mul_overflow` in 1: datapath flag, valid in final multiply step cycle.
- `load` out 1: datapath captures operands.
- `step` out 1: datapath advances one iteration.
- `mode_div` out 1: 1 = divide, 0 = multiply; latched at start.
- `count` out CW: current iteration index.
- `busy` out 1: high in LOAD and RUN.
- `data_resultRDY` out 1: one-cycle result-valid pulse.
- `data_exception` out 1: valid only while `data_resultRDY`=1, else 0.

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs registered or decoded from state/count only; no input-to-output combinational path.
- IDLE: all outputs 0. Start pulse → LOAD, latch `mode_div`, clear exception flag.
- LOAD: `load`=1 for one cycle. Latch `divisor_zero` if `mode_div`. → RUN (see Configuration for divide-by-zero).
- RUN: `step`=1 every cycle, `count` 0..N-1 (N=`STEPS_DIV` if `mode_div`, else `STEPS_MUL`). At `count`=N-1: multiply ORs `mul_overflow` into exception flag; → DONE.
- DONE: `data_resultRDY`=1, `data_exception`=flag, one cycle. → IDLE, or → LOAD if a start is sampled in this cycle.
- Start in LOAD/RUN: abort; restart at LOAD with new mode, count reset, flag cleared; no RDY issued for the aborted op.
- `ctrl_MULT` and `ctrl_DIV` together: multiply wins.
- `count` is 0 outside RUN; never wraps (terminal compare ends RUN).
- `reset` in any state → IDLE next edge; all outputs 0 in the following cycle; in-flight op dropped silently.

## Timing
- Start sampled at edge E0 → `load` in cycle 1, `step` in cycles 2..N+1, `data_resultRDY` in cycle N+2.
- Multiply (16): RDY in cycle 18. Divide (32): RDY in cycle 34.
- `busy` high cycles 1..N+1; low in DONE, so back-to-back start is accepted in the RDY cycle.
- Fast divide-by-zero (macro on): `load` cycle 1, RDY+exception cycle 2.

## Configuration
- `MULTDIV_DIV0_FAST_EN` defined: in LOAD with `mode_div`=1 and `divisor_zero`=1, skip RUN → DONE with exception; no `step` pulses.
- Undefined: divide-by-zero runs all `STEPS_DIV` steps; exception reported at normal RDY (cycle 34). Datapath result is don't-care in either case.

## Structure
- `multdiv_pkg`: state enum (IDLE/LOAD/RUN/DONE), default `STEPS_MUL`/`STEPS_DIV` constants, mode encoding.
- One sub-module `tff_counter`: CW-bit synchronous ripple-carry counter built from the existing T flip-flop cells, with synchronous clear; FSM drives clear/enable and decodes terminal count.

## Test plan
- Reset held 3 cycles mid-RUN → all outputs 0 next cycle, no RDY afterwards.
- `ctrl_MULT` pulse, `mul_overflow`=0 → `load` cycle 1, 16 `step`s with `count` 0..15, RDY cycle 18, exception 0; repeat with `mul_overflow`=1 on step 15 → exception 1.
- `ctrl_DIV` pulse, `divisor_zero`=0 → 32 steps, `mode_div`=1, RDY cycle 34, exception 0.
- `ctrl_DIV` with `divisor_zero`=1 → macro on: RDY+exception cycle 2, zero steps; macro off: RDY+exception cycle 34.
- `ctrl_DIV` then `ctrl_MULT` at cycle 10 → divide aborted, single RDY at cycle 28 with `mode_div`=0.
- Both starts in same cycle, then new start during DONE → multiply selected; second op's `load` in cycle immediately after RDY.
